// File: rtl/bus_arb_pkg.sv
// Shared definitions for the 4-way round-robin bus arbiter.
// Exports: NUM_REQ, bus_arb_state_t {IDLE, OWN}, rr_next(req, ptr) -> winner index.
// rr_next is pure combinational logic; no ports or clocking here.
package bus_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } bus_arb_state_t;

  // Search ptr+1, ptr+2, ptr+3, ptr (mod 4). Walking from the farthest
  // candidate back to the nearest lets the nearest requester overwrite last.
  // Returns ptr when nothing is requesting; callers qualify with |req.
  function automatic logic [1:0] rr_next(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         ptr);
    logic [1:0] idx;
    rr_next = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin picker for the bus arbiter.
// Ports: req (per-requester request), ptr (last owner) -> winner, any_req.
// Zero latency; winner is only meaningful while any_req is high.
module bus_arb_rr_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         winner,
  output logic               any_req
);

  assign winner  = rr_next(req, ptr);
  assign any_req = |req;

endmodule

// File: rtl/mux_4to1.sv
// 16-bit 4:1 data mux driving the shared internal bus.
// Ports: D0..D3 data inputs, S select, Y selected word.
// Purely combinational; no clock, no backpressure.
module mux_4to1 (
  input  logic [15:0] D0,
  input  logic [15:0] D1,
  input  logic [15:0] D2,
  input  logic [15:0] D3,
  input  logic [1:0]  S,
  output logic [15:0] Y
);

  always_comb begin
    Y = D0;
    case (S)
      2'd0:    Y = D0;
      2'd1:    Y = D1;
      2'd2:    Y = D2;
      default: Y = D3;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter/sequencer for the shared 16-bit bus: one owner at a time,
// drives the mux select and registers each transferred beat onto bus_out.
// Ports: Clk, Reset (sync, active-low), req/last/din0..3 in; gnt, sel, bus_valid,
// bus_out, busy, timeout out. Grant 1 cycle after req; data 1 cycle after beat.
// Optional macro BUS_ARB_TIMEOUT_EN: revoke ownership after MAX_HOLD beats when
// another requester waits (timeout pulse); when undefined, timeout is tied to 0.
module bus_arbiter_4
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  req,
  input  logic [3:0]  last,
  input  logic [15:0] din0,
  input  logic [15:0] din1,
  input  logic [15:0] din2,
  input  logic [15:0] din3,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic        bus_valid,
  output logic [15:0] bus_out,
  output logic        busy,
  output logic        timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter_4: MAX_HOLD must be in 1..255");
  end

  bus_arb_state_t state_q, state_d;
  logic [3:0]     gnt_q, gnt_d;
  logic [1:0]     sel_q, sel_d;
  logic [1:0]     ptr_q, ptr_d;
  logic           valid_q, valid_d;
  logic [15:0]    data_q, data_d;
  logic           tmo_q, tmo_d;
  logic [1:0]     winner;
  logic           any_req;
  logic [15:0]    mux_y;

  bus_arb_rr_pick u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  mux_4to1 u_mux (
    .D0 (din0),
    .D1 (din1),
    .D2 (din2),
    .D3 (din3),
    .S  (sel_q),
    .Y  (mux_y)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [8:0] HOLD9 = 9'(MAX_HOLD);

  logic [7:0] cnt_q, cnt_d;
  logic [8:0] beats_now;
  logic       other_req;

  // Beats including the one on this edge; 9 bits so 255+1 cannot wrap.
  assign beats_now = {1'b0, cnt_q} + 9'd1;
  assign other_req = |(req & ~gnt_q);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    data_d  = data_q;
    tmo_d   = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = OWN;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          ptr_d   = winner;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      OWN: begin
        if (!req[sel_q]) begin
          // Owner withdrew: release without capturing.
          state_d = IDLE;
          gnt_d   = '0;
        end else begin
          valid_d = 1'b1;
          data_d  = mux_y;
          if (last[sel_q]) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          // ptr already names this owner, so it is searched last next time.
          else if (beats_now >= HOLD9 && other_req) begin
            state_d = IDLE;
            gnt_d   = '0;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = (beats_now >= HOLD9) ? HOLD9[7:0] : beats_now[7:0];
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= 2'd3;
      valid_q <= 1'b0;
      data_q  <= '0;
      tmo_q   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign bus_valid = valid_q;
  assign bus_out   = data_q;
  assign busy      = (state_q == OWN);
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_bus_arbiter_4.sv
module tb_bus_arbiter_4;

  localparam int HOLD = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  last = '0;
  logic [15:0] din [4];
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        bus_valid;
  logic [15:0] bus_out;
  logic        busy;
  logic        timeout;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: owner index (-1 = bus free), last owner, beat count.
  int          m_owner;
  int          m_ptr;
  int          m_beats;
  logic [1:0]  m_sel;
  logic        m_valid;
  logic        m_tmo;
  logic [15:0] m_out;

  bus_arbiter_4 #(.MAX_HOLD(HOLD)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .last      (last),
    .din0      (din[0]),
    .din1      (din[1]),
    .din2      (din[2]),
    .din3      (din[3]),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .bus_out   (bus_out),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the behavioural model, from inputs present at the edge.
  task automatic model_edge();
    bit others;
    if (!Reset) begin
      m_owner = -1; m_ptr = 3; m_beats = 0;
      m_sel = 2'd0; m_valid = 1'b0; m_tmo = 1'b0; m_out = 16'h0;
      return;
    end
    m_valid = 1'b0;
    m_tmo   = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (req[c]) begin
          m_owner = c; m_ptr = c; m_sel = 2'(c); m_beats = 0;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else begin
      m_valid = 1'b1;
      m_out   = din[m_owner];
      m_beats++;
      others  = (req & ~(4'b0001 << m_owner)) != 4'b0000;
      if (last[m_owner]) m_owner = -1;
      else if (TMO && m_beats >= HOLD && others) begin
        m_owner = -1;
        m_tmo   = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check("gnt",       32'(gnt),       (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("sel",       32'(sel),       32'(m_sel));
    check("bus_valid", 32'(bus_valid), 32'(m_valid));
    check("bus_out",   32'(bus_out),   32'(m_out));
    check("busy",      32'(busy),      32'(m_owner >= 0));
    check("timeout",   32'(timeout),   32'(m_tmo));
  endtask

  task automatic do_reset();
    Reset = 1'b0; req = '0; last = '0;
    step();
    Reset = 1'b1;
  endtask

  initial begin
    int nvalid;
    logic [3:0] rr_order [5];
    for (int i = 0; i < 4; i++) din[i] = 16'h0;
    rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;

    @(negedge Clk);
    do_reset();
    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_out", 32'(bus_out), 32'd0);

    // Three-beat transfer on requester 0.
    req = 4'b0001; din[0] = 16'h1111;
    step();
    check("t1_gnt", 32'(gnt), 32'h1);
    step();
    check("t1_b1", 32'(bus_out), 32'h1111);
    din[0] = 16'h2222;
    step();
    check("t1_b2", 32'(bus_out), 32'h2222);
    din[0] = 16'h3333; last = 4'b0001;
    step();
    check("t1_b3", 32'(bus_out), 32'h3333);
    check("t1_v3", 32'(bus_valid), 32'h1);
    check("t1_rel", 32'(gnt), 32'h0);
    req = '0; last = '0;
    step();

    // All four requesting, single-beat transfers: 0,1,2,3,0 with one idle gap.
    do_reset();
    req = 4'b1111; last = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_gnt", 32'(gnt), 32'(rr_order[i]));
      step();
      check("rr_gap", 32'(gnt), 32'h0);
    end
    req = '0; last = '0;

    // Requester 2 never signals last while requester 1 waits.
    do_reset();
    req = 4'b0100; din[2] = 16'hC0DE;
    step();
    check("to_gnt2", 32'(gnt), 32'h4);
    req = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_early", 32'(timeout), 32'h0);
    end
    step();
`ifdef BUS_ARB_TIMEOUT_EN
    check("to_pulse", 32'(timeout), 32'h1);
    check("to_rel",   32'(gnt), 32'h0);
    step();
    check("to_next",  32'(gnt), 32'h2);
    check("to_clr",   32'(timeout), 32'h0);
`else
    for (int i = 0; i < 8; i++) begin
      check("nto_hold", 32'(gnt), 32'h4);
      check("nto_tmo",  32'(timeout), 32'h0);
      step();
    end
`endif
    req = '0;
    step();
    step();

    // Owner drops req after two beats.
    do_reset();
    req = 4'b0001; nvalid = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) req = '0;
      din[0] = 16'(16'hA000 + i);
      step();
      nvalid += int'(bus_valid);
      if (i == 2) check("drop_gnt", 32'(gnt), 32'h0);
    end
    check("drop_cnt", 32'(nvalid), 32'd2);

    // Reset during beat 2.
    do_reset();
    req = 4'b0001; din[0] = 16'h5A5A;
    step();
    step();
    Reset = 1'b0;
    step();
    check("mr_gnt", 32'(gnt), 32'h0);
    check("mr_out", 32'(bus_out), 32'h0);
    check("mr_vld", 32'(bus_valid), 32'h0);
    Reset = 1'b1; req = 4'b1111;
    step();
    check("mr_win0", 32'(gnt), 32'h1);
    req = '0;
    step();
    step();

    // Randomised traffic with sticky requests.
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) req[b] = ~req[b];
        last[b] = ($urandom_range(4) == 0);
        din[b]  = 16'($urandom);
      end
      Reset = ($urandom_range(80) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
